fir_line_buffer: RTL and testbench

FIR_LINE_BUFFER -- requirements
Module: fir_line_buffer

---
 rtl/fir_line_buffer_pkg.sv | 32 +++
 rtl/fir_line_buffer_if.sv | 39 +++
 rtl/line_ram.sv | 37 +++
 rtl/fir_line_buffer.sv | 158 +++++++++++++++
 tb/tb_fir_line_buffer.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_line_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_line_buffer_pkg
// Description : Shared constants and types for the 5-tap vertical line buffer
//               and the downstream 5x5 filter.
// Revision    : 1.0
// ============================================================================
package fir_line_buffer_pkg;

  localparam int LATENCY  = 2;
  localparam int PIX_W    = 8;
  localparam int NUM_TAPS = 5;
  localparam int NUM_RAMS = NUM_TAPS - 1;
  localparam int LCNT_W   = 3;

  // Line count at which every tap row holds a real line of the current frame
  localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(NUM_TAPS - 1);

  typedef logic [PIX_W-1:0] pixel_t;

  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
  } sync_t;

  function automatic pixel_t mask_tap(input pixel_t pix, input logic keep);
    return keep ? pix : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_line_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_line_buffer_if
// Description : Raster input and 5-tap column output bundle of the line buffer.
// Revision    : 1.0
// ============================================================================
interface fir_line_buffer_if;
  import fir_line_buffer_pkg::*;

  logic   dv_i;
  logic   hs_i;
  logic   vs_i;
  pixel_t pixel_i;

  pixel_t pixel0;
  pixel_t pixel1;
  pixel_t pixel2;
  pixel_t pixel3;
  pixel_t pixel4;
  logic   dv_o;
  logic   hs_o;
  logic   vs_o;
  logic   win_full_o;
  logic   ovf_o;

  modport master (
    output dv_i, hs_i, vs_i, pixel_i,
    input  pixel0, pixel1, pixel2, pixel3, pixel4,
    input  dv_o, hs_o, vs_o, win_full_o, ovf_o
  );

  modport slave (
    input  dv_i, hs_i, vs_i, pixel_i,
    output pixel0, pixel1, pixel2, pixel3, pixel4,
    output dv_o, hs_o, vs_o, win_full_o, ovf_o
  );

endinterface
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
// Module      : line_ram
// Description : Simple dual-port line memory, one write and one registered read.
// Revision    : 1.0
// ============================================================================
module line_ram #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  wire              clk,
  input  wire              we,
  input  wire [ADDR_W-1:0] waddr,
  input  wire [DATA_W-1:0] wdata,
  input  wire              re,
  input  wire [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Same-address read and write in one cycle returns the old contents
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fir_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fir_line_buffer
// Description : Four-line cascade buffer producing a zero-padded 5-tap column.
// Revision    : 1.0
// ============================================================================
module fir_line_buffer
  import fir_line_buffer_pkg::*;
#(
  parameter int MAX_WIDTH = 2048,
  parameter int ADDR_W    = 11
) (
  input  wire              clk,
  input  wire              rst,
  fir_line_buffer_if.slave bus
);

  localparam logic [ADDR_W-1:0] c_col_last = ADDR_W'(MAX_WIDTH - 1);

  logic              r_dv_prev;
  logic              r_vs_prev;
  logic              w_dv_fall;
  logic              w_vs_rise;
  logic              w_wr0;
  logic [ADDR_W-1:0] r_col;
  logic              r_col_full;
  logic [LCNT_W-1:0] r_lcnt;
  logic              r_ovf;
  sync_t             w_sync_in;

  sync_t             r_sync [LATENCY];
  pixel_t            r_pix_d1;
  logic [ADDR_W-1:0] r_col_d1;
  logic              r_wr_d1;
  logic [LCNT_W-1:0] r_lcnt_d1;
  pixel_t            w_rd [NUM_RAMS];

  pixel_t            r_tap [NUM_TAPS];
  logic              r_win_full;

  assign w_dv_fall = r_dv_prev & ~bus.dv_i;
  assign w_vs_rise = bus.vs_i & ~r_vs_prev;
  // Once the last column has been written, further pixels of the line are dropped
  assign w_wr0     = bus.dv_i & ~r_col_full & ~rst;
  assign w_sync_in = {bus.dv_i, bus.hs_i, bus.vs_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dv_prev  <= 1'b0;
      r_vs_prev  <= 1'b0;
      r_col      <= '0;
      r_col_full <= 1'b0;
      r_lcnt     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_dv_prev <= bus.dv_i;
      r_vs_prev <= bus.vs_i;
      if (w_vs_rise) begin
        r_col      <= '0;
        r_col_full <= 1'b0;
        r_lcnt     <= '0;
        r_ovf      <= 1'b0;
      end else if (w_dv_fall) begin
        r_col      <= '0;
        r_col_full <= 1'b0;
        if (r_lcnt != LCNT_MAX) begin
          r_lcnt <= r_lcnt + 1'b1;
        end
      end else if (bus.dv_i) begin
        if (r_col_full) begin
          r_ovf <= 1'b1;
        end else if (r_col == c_col_last) begin
          r_col_full <= 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Stage 1 captures the entry context; stage 2 combines it with the RAM reads
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_sync[i] <= '0;
      end
      r_pix_d1   <= '0;
      r_col_d1   <= '0;
      r_wr_d1    <= 1'b0;
      r_lcnt_d1  <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_tap[k] <= '0;
      end
      r_win_full <= 1'b0;
    end else begin
      r_sync[0] <= w_sync_in;
      for (int i = 1; i < LATENCY; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_pix_d1  <= bus.pixel_i;
      r_col_d1  <= r_col;
      r_wr_d1   <= w_wr0;
      r_lcnt_d1 <= r_lcnt;

      r_tap[0] <= mask_tap(r_pix_d1, r_sync[0].dv);
      for (int k = 1; k < NUM_TAPS; k++) begin
        r_tap[k] <= mask_tap(w_rd[k-1], r_sync[0].dv && (r_lcnt_d1 >= LCNT_W'(k)));
      end
      r_win_full <= r_sync[0].dv && (r_lcnt_d1 == LCNT_MAX);
    end
  end

  generate
    for (genvar k = 0; k < NUM_RAMS; k++) begin : g_ram
      pixel_t            w_wdata;
      logic              w_we;
      logic [ADDR_W-1:0] w_waddr;

      if (k == 0) begin : g_head
        assign w_wdata = bus.pixel_i;
        assign w_we    = w_wr0;
        assign w_waddr = r_col;
      end else begin : g_tail
        // Each older line is the previous RAM's read data, shifted down one row
        assign w_wdata = w_rd[k-1];
        assign w_we    = r_wr_d1;
        assign w_waddr = r_col_d1;
      end

      line_ram #(
        .DEPTH  (MAX_WIDTH),
        .ADDR_W (ADDR_W),
        .DATA_W (PIX_W)
      ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .re    (bus.dv_i),
        .raddr (r_col),
        .rdata (w_rd[k])
      );
    end
  endgenerate

  assign bus.pixel0     = r_tap[0];
  assign bus.pixel1     = r_tap[1];
  assign bus.pixel2     = r_tap[2];
  assign bus.pixel3     = r_tap[3];
  assign bus.pixel4     = r_tap[4];
  assign bus.dv_o       = r_sync[LATENCY-1].dv;
  assign bus.hs_o       = r_sync[LATENCY-1].hs;
  assign bus.vs_o       = r_sync[LATENCY-1].vs;
  assign bus.win_full_o = r_win_full;
  assign bus.ovf_o      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fir_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_line_buffer
// Description : Self-checking bench for fir_line_buffer with a frame-level model.
// Revision    : 1.0
// ============================================================================
module tb_fir_line_buffer;
  import fir_line_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fir_line_buffer_if bus_main ();
  fir_line_buffer_if bus_small ();

  fir_line_buffer #(.MAX_WIDTH(2048), .ADDR_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_main.slave)
  );

  fir_line_buffer #(.MAX_WIDTH(16), .ADDR_W(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus_small.slave)
  );

  // Reference: frame as (line, column) -> pixel since the last vsync or reset
  typedef struct packed {
    logic            known;
    logic            dv;
    logic            hs;
    logic            vs;
    logic            win;
    logic [4:0][7:0] pix;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_frame [int];
  int         m_line = 0;
  int         m_col  = 0;
  logic       m_prev_dv = 1'b0;
  logic       m_prev_vs = 1'b0;

  function automatic logic [43:0] exp_vec(input exp_t e);
    return {e.dv, e.hs, e.vs, e.win, e.pix[0], e.pix[1], e.pix[2], e.pix[3], e.pix[4]};
  endfunction

  function automatic logic [43:0] obs_vec();
    return {bus_main.dv_o, bus_main.hs_o, bus_main.vs_o, bus_main.win_full_o,
            bus_main.pixel0, bus_main.pixel1, bus_main.pixel2, bus_main.pixel3, bus_main.pixel4};
  endfunction

  // Apply one input cycle to both DUTs, advance the model, wait one clock
  task automatic step(input logic dv, input logic hs, input logic vs, input logic [7:0] pix);
    exp_t e;
    exp_t z;
    z       = '0;
    z.known = 1'b1;
    e       = '0;
    e.known = 1'b1;
    e.dv    = dv & ~rst;
    e.hs    = hs & ~rst;
    e.vs    = vs & ~rst;
    e.win   = e.dv && (m_line >= 4);
    e.pix[0] = e.dv ? pix : 8'h00;
    for (int k = 1; k < 5; k++) begin
      if (e.dv && m_line >= k) begin
        if (m_frame.exists((m_line - k) * 4096 + m_col)) e.pix[k] = m_frame[(m_line - k) * 4096 + m_col];
        else e.known = 1'b0;
      end
    end
    if (rst) begin
      for (int i = 0; i < exp_q.size(); i++) exp_q[i] = z;
      m_frame.delete();
      m_line = 0;
      m_col = 0;
      m_prev_dv = 1'b0;
      m_prev_vs = 1'b0;
    end else begin
      if (vs && !m_prev_vs) begin
        m_frame.delete();
        m_line = 0;
        m_col = 0;
      end else if (!dv && m_prev_dv) begin
        m_line++;
        m_col = 0;
      end else if (dv) begin
        m_frame[m_line * 4096 + m_col] = pix;
        m_col++;
      end
      m_prev_dv = dv;
      m_prev_vs = vs;
    end
    exp_q.push_back(e);
    bus_main.dv_i     = dv;
    bus_main.hs_i     = hs;
    bus_main.vs_i     = vs;
    bus_main.pixel_i  = pix;
    bus_small.dv_i    = dv;
    bus_small.hs_i    = hs;
    bus_small.vs_i    = vs;
    bus_small.pixel_i = pix;
    @(posedge clk);
    #1;
    if (exp_q.size() > 2) void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) step(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    checks++;
    if ({bus_main.dv_o, bus_main.hs_o, bus_main.vs_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_sync: got %b expected 000", {bus_main.dv_o, bus_main.hs_o, bus_main.vs_o});
    end
    checks++;
    if ({bus_main.pixel0, bus_main.pixel1, bus_main.pixel2, bus_main.pixel3, bus_main.pixel4} !== 40'h0) begin
      errors++;
      $display("FAIL reset_pixels: got %h expected 0",
               {bus_main.pixel0, bus_main.pixel1, bus_main.pixel2, bus_main.pixel3, bus_main.pixel4});
    end
    checks++;
    if ({bus_main.win_full_o, bus_main.ovf_o, bus_small.ovf_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {bus_main.win_full_o, bus_main.ovf_o, bus_small.ovf_o});
    end
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (obs_vec() !== 44'h0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected 0", obs_vec());
    end
  endtask

  task automatic test_sync_pulse();
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'hAB);
    checks++;
    if ({bus_main.dv_o, bus_main.hs_o, bus_main.vs_o} !== 3'b000) begin
      errors++;
      $display("FAIL pulse_early: got %b expected 000", {bus_main.dv_o, bus_main.hs_o, bus_main.vs_o});
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({bus_main.dv_o, bus_main.hs_o, bus_main.vs_o, bus_main.pixel0} !== {3'b111, 8'hAB}) begin
      errors++;
      $display("FAIL pulse_on_time: got %h expected 7ab",
               {bus_main.dv_o, bus_main.hs_o, bus_main.vs_o, bus_main.pixel0});
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({bus_main.dv_o, bus_main.hs_o, bus_main.vs_o, bus_main.pixel0} !== 11'h0) begin
      errors++;
      $display("FAIL pulse_width: got %h expected 0",
               {bus_main.dv_o, bus_main.hs_o, bus_main.vs_o, bus_main.pixel0});
    end
  endtask

  task automatic test_first_line();
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b1, 1'b0, 8'(c));
      if (c == 3) begin
        checks++;
        if ({bus_main.pixel0, bus_main.pixel1, bus_main.pixel2, bus_main.pixel3, bus_main.pixel4,
             bus_main.win_full_o} !== {8'h02, 32'h0, 1'b0}) begin
          errors++;
          $display("FAIL first_line_col2: got %h expected 02000000000 win 0",
                   {bus_main.pixel0, bus_main.pixel1, bus_main.pixel2, bus_main.pixel3,
                    bus_main.pixel4, 3'b000, bus_main.win_full_o});
        end
      end
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_full_window();
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int l = 0; l < 6; l++) begin
      for (int c = 0; c < 8; c++) begin
        step(1'b1, 1'b1, 1'b0, 8'(l * 16 + c));
        if (l >= 3 && c == 4) begin
          checks++;
          if (bus_main.win_full_o !== (l >= 4)) begin
            errors++;
            $display("FAIL win_full_line%0d: got %b expected %b", l, bus_main.win_full_o, (l >= 4));
          end
        end
        if (l == 5 && c == 4) begin
          checks++;
          if ({bus_main.pixel0, bus_main.pixel1, bus_main.pixel2, bus_main.pixel3, bus_main.pixel4}
              !== 40'h53_43_33_23_13) begin
            errors++;
            $display("FAIL window_l5_c3: got %h expected 5343332313",
                     {bus_main.pixel0, bus_main.pixel1, bus_main.pixel2, bus_main.pixel3, bus_main.pixel4});
          end
        end
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic test_vs_same_cycle();
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b0, 8'(8'h10 + c));
    // dv falls exactly as vs rises: the line count must stay at zero
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'b1, 1'b0, 8'(8'h20 + c));
      if (c == 2) begin
        checks++;
        if ({bus_main.pixel0, bus_main.pixel1} !== 16'h21_00) begin
          errors++;
          $display("FAIL vs_beats_fall: got %h expected 2100", {bus_main.pixel0, bus_main.pixel1});
        end
      end
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_overflow();
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (bus_small.ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_start: got %b expected 0", bus_small.ovf_o);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(i));
      if (i == 15 || i == 16) begin
        checks++;
        if (bus_small.ovf_o !== (i == 16)) begin
          errors++;
          $display("FAIL ovf_after_pixel%0d: got %b expected %b", i + 1, bus_small.ovf_o, (i == 16));
        end
      end
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (bus_small.ovf_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b expected 1", bus_small.ovf_o);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    checks++;
    if (bus_small.ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_vs_clear: got %b expected 0", bus_small.ovf_o);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_midline_reset();
    logic [7:0] e0;
    logic [7:0] e1;
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 1'b0, 8'(8'h40 + l * 16 + c));
      step(1'b0, 1'b0, 1'b0, 8'h00);
    end
    for (int c = 0; c < 5; c++) step(1'b1, 1'b1, 1'b0, 8'(8'h60 + c));
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 8'h65);
    rst = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 8; c++) begin
        step(1'b1, 1'b1, 1'b0, 8'(8'hA0 + l * 16 + c));
        if (c >= 1) begin
          e0 = 8'(8'hA0 + l * 16 + c - 1);
          e1 = (l == 1) ? 8'(8'hA0 + c - 1) : 8'h00;
          checks++;
          if ({bus_main.pixel0, bus_main.pixel1, bus_main.pixel2, bus_main.pixel3, bus_main.pixel4}
              !== {e0, e1, 24'h0}) begin
            errors++;
            $display("FAIL rst_line%0d_col%0d: got %h expected %h", l, c - 1,
                     {bus_main.pixel0, bus_main.pixel1, bus_main.pixel2, bus_main.pixel3, bus_main.pixel4},
                     {e0, e1, 24'h0});
          end
        end
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic test_random_frame();
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int l = 0; l < 6; l++) begin
      for (int c = 0; c <= 1920; c++) begin
        if (c < 1920) step(1'b1, 1'($urandom), 1'b0, 8'($urandom));
        else step(1'b0, 1'b0, 1'b0, 8'($urandom));
        if (exp_q.size() == 2 && exp_q[0].known) begin
          checks++;
          if (obs_vec() !== exp_vec(exp_q[0])) begin
            errors++;
            $display("FAIL frame_l%0d_c%0d: got %h expected %h", l, c, obs_vec(), exp_vec(exp_q[0]));
          end
        end
      end
    end
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_sync_pulse();
    test_first_line();
    test_full_window();
    test_vs_same_cycle();
    test_overflow();
    test_midline_reset();
    test_random_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
